data_sram_responder: RTL

- SRAM-like data-side slave that answers the request/response handshake the pipeline's memory stage consumes (`data_sram_dataok`/`data_sram_rdata`).
- Accepts requests with `addr_ok` and queues them in order.
- Each request is served after a programmable latency and completes with a one-cycle `data_ok` pulse carrying the full read word.
- Used as the data memory model for pipeline bring-up and as the reference slave for bus-bridge verification.

---
 rtl/data_sram_if.sv | 22 ++
 rtl/data_sram_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/data_sram_if.sv
// Request/response handshake between a memory-stage requester and a data SRAM slave.
interface data_sram_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        dataok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, dataok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, dataok, rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// In-order SRAM-like data slave: queues accepted requests, performs the access
// at retire after a programmable latency and answers with a one-cycle dataok pulse.
module data_sram_responder #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 1,
    parameter int QDEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    data_sram_if.slave   bus
);
    localparam int PW = $clog2(QDEPTH);

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [3:0]        wstrb;
        logic [MEM_AW+1:0] addr;
        logic [31:0]       wdata;
    } entry_t;

    entry_t          queue_mem [QDEPTH];
    logic [3:0]      wait_cnt  [QDEPTH];
    logic [31:0]     mem       [2**MEM_AW];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            dataok;
    logic [31:0]     rdata;

    logic            accept;
    logic            retire;
    logic            misaligned;
    entry_t          head;
    logic [MEM_AW-1:0] head_idx;
    logic            unused_addr;

    // NOTE: addr_ok is combinational and deliberately ignores a same-cycle retire.
    assign accept = bus.req && (count != (PW+1)'(QDEPTH)) && !reset;
    assign retire = (count != '0) && (wait_cnt[rd_ptr] == 4'd0);

    assign head       = queue_mem[rd_ptr];
    assign head_idx   = head.addr[MEM_AW+1:2];
    assign misaligned = ((head.size == 2'd1) && head.addr[0]) ||
                        (head.size[1] && (head.addr[1:0] != 2'b00));

    assign unused_addr = ^bus.addr[31:MEM_AW+2];

    assign bus.addr_ok = accept;
    assign bus.dataok  = dataok;
    assign bus.rdata   = rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dataok <= 1'b0;
            rdata  <= 32'h0;
            for (int i = 0; i < QDEPTH; i++) begin
                wait_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (wait_cnt[i] != 4'd0) begin
                    wait_cnt[i] <= wait_cnt[i] - 4'd1;
                end
            end
            if (accept) begin
                wait_cnt[wr_ptr] <= 4'(LATENCY - 1);
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= head.wr ? 32'h0 : mem[head_idx];
            end
            dataok <= retire;
            case ({accept, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue payload and memory array carry no reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            queue_mem[wr_ptr] <= '{wr:    bus.wr,
                                   size:  bus.size,
                                   wstrb: bus.wstrb,
                                   addr:  bus.addr[MEM_AW+1:0],
                                   wdata: bus.wdata};
        end
        if (retire && head.wr && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (head.wstrb[i]) begin
                    mem[head_idx][8*i +: 8] <= head.wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
